// File: rtl/stream_demux_if.sv
// Stream demultiplexer bus: multiplexed input stream plus per-channel outputs.
interface stream_demux_if;
    logic [7:0]  DATA_IN;
    logic        D_VALID_IN;
    logic        P_SYNC_IN;
    logic [7:0]  DATA_OUT;
    logic [3:0]  D_VALID_OUT;
    logic [3:0]  P_SYNC_OUT;
    logic [1:0]  PLP_OUT;
    logic [2:0]  ERR_PULSE;
    logic [15:0] ERR_COUNT;

    modport slave (
        input  DATA_IN, D_VALID_IN, P_SYNC_IN,
        output DATA_OUT, D_VALID_OUT, P_SYNC_OUT, PLP_OUT, ERR_PULSE, ERR_COUNT
    );

    modport master (
        output DATA_IN, D_VALID_IN, P_SYNC_IN,
        input  DATA_OUT, D_VALID_OUT, P_SYNC_OUT, PLP_OUT, ERR_PULSE, ERR_COUNT
    );
endinterface

// File: rtl/stream_demux.sv
// Receive-side TS demultiplexer: validates the 4-byte pseudo-header and the
// TS sync byte, then steers the 188-byte payload onto one of 4 channel write
// strobes. Malformed packets are dropped and counted (saturating).
module stream_demux #(
    parameter logic [7:0]  SYNC_BYTE   = 8'h47,
    parameter int unsigned PAYLOAD_LEN = 188,
    parameter int unsigned HDR_LEN     = 4,
    parameter logic [7:0]  SRC_OFFSET  = 8'd2,
    parameter bit          CHECK_SRC   = 1'b1
) (
    input  logic           SYS_CLK,
    input  logic           RST,
    stream_demux_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DISCARD} state_t;

    localparam logic [7:0] LAST_HDR = 8'(HDR_LEN - 1);
    localparam logic [7:0] FIRST_TS = 8'(HDR_LEN);
    localparam logic [7:0] LAST_TS  = 8'(HDR_LEN + PAYLOAD_LEN - 1);

    state_t      state;
    logic [7:0]  byte_cnt;
    logic [7:0]  plp_id;
    logic [7:0]  src;
    // Set once the last TS byte has been forwarded; the following cycle
    // decides between a clean end and an overlength packet.
    logic        tail;
    logic        hdr_bad;
    logic        sync_bad;
    logic [3:0]  ch_onehot;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    // Header validity, sync-byte check and channel decode for the FSM.
    always_comb begin
        hdr_bad   = (plp_id > 8'd3) ||
                    (CHECK_SRC && (src != 8'(plp_id + SRC_OFFSET)));
        sync_bad  = (bus.DATA_IN != SYNC_BYTE) || !bus.P_SYNC_IN;
        ch_onehot = 4'b0001 << bus.PLP_OUT;
    end

    // Packet FSM with registered outputs and saturating error counter.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state           <= IDLE;
            byte_cnt        <= '0;
            plp_id          <= '0;
            src             <= '0;
            tail            <= 1'b0;
            bus.DATA_OUT    <= '0;
            bus.D_VALID_OUT <= '0;
            bus.P_SYNC_OUT  <= '0;
            bus.PLP_OUT     <= '0;
            bus.ERR_PULSE   <= '0;
            bus.ERR_COUNT   <= '0;
        end else begin
            bus.ERR_PULSE   <= '0;
            bus.D_VALID_OUT <= '0;
            bus.P_SYNC_OUT  <= '0;
            case (state)
                IDLE: begin
                    if (bus.D_VALID_IN) begin
                        plp_id   <= bus.DATA_IN;
                        byte_cnt <= 8'd1;
                        tail     <= 1'b0;
                        state    <= HEADER;
                    end
                end
                HEADER: begin
                    if (!bus.D_VALID_IN) begin
                        bus.ERR_PULSE <= 3'b100;
                        bus.ERR_COUNT <= sat_inc(bus.ERR_COUNT);
                        byte_cnt      <= '0;
                        state         <= IDLE;
                    end else if (byte_cnt == LAST_HDR) begin
                        if (hdr_bad) begin
                            bus.ERR_PULSE <= 3'b001;
                            bus.ERR_COUNT <= sat_inc(bus.ERR_COUNT);
                            state         <= DISCARD;
                        end else begin
                            bus.PLP_OUT <= plp_id[1:0];
                            byte_cnt    <= FIRST_TS;
                            state       <= PAYLOAD;
                        end
                    end else begin
                        if (byte_cnt == 8'd1)
                            src <= bus.DATA_IN;
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                PAYLOAD: begin
                    if (tail) begin
                        tail     <= 1'b0;
                        byte_cnt <= '0;
                        if (bus.D_VALID_IN) begin
                            bus.ERR_PULSE <= 3'b100;
                            bus.ERR_COUNT <= sat_inc(bus.ERR_COUNT);
                            state         <= DISCARD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!bus.D_VALID_IN) begin
                        bus.ERR_PULSE <= 3'b100;
                        bus.ERR_COUNT <= sat_inc(bus.ERR_COUNT);
                        byte_cnt      <= '0;
                        state         <= IDLE;
                    end else if ((byte_cnt == FIRST_TS) && sync_bad) begin
                        bus.ERR_PULSE <= 3'b010;
                        bus.ERR_COUNT <= sat_inc(bus.ERR_COUNT);
                        state         <= DISCARD;
                    end else begin
                        bus.DATA_OUT    <= bus.DATA_IN;
                        bus.D_VALID_OUT <= ch_onehot;
                        if (byte_cnt == FIRST_TS)
                            bus.P_SYNC_OUT <= ch_onehot;
                        if (byte_cnt == LAST_TS)
                            tail <= 1'b1;
                        else
                            byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                DISCARD: begin
                    if (!bus.D_VALID_IN) begin
                        byte_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: directed packets push expected strobes
// and error pulses; a negedge monitor pops and compares.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    stream_demux_if bus0();
    stream_demux_if bus1();

    stream_demux #(.CHECK_SRC(1'b1)) dut0 (.SYS_CLK(clk), .RST(rst_n), .bus(bus0));
    stream_demux #(.CHECK_SRC(1'b0)) dut1 (.SYS_CLK(clk), .RST(rst_n), .bus(bus1));

    typedef struct {
        logic [3:0] ch;
        logic [7:0] data;
        logic [3:0] ps;
        logic [1:0] plp;
    } strobe_t;

    strobe_t    exp_q[$];
    logic [2:0] err_q[$];
    strobe_t    mon_e;
    logic [2:0] mon_err;
    int tests = 0;
    int fails = 0;
    int cnt1_ch1 = 0;
    int strobe_cnt[4] = '{0, 0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for dut0, plus a ch1 strobe counter for dut1.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus0.D_VALID_OUT != 4'b0000) begin
                tests++;
                for (int c = 0; c < 4; c++)
                    if (bus0.D_VALID_OUT[c]) strobe_cnt[c]++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe: got dv=%b data=%h expected none",
                             bus0.D_VALID_OUT, bus0.DATA_OUT);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus0.D_VALID_OUT !== mon_e.ch || bus0.DATA_OUT !== mon_e.data ||
                        bus0.P_SYNC_OUT !== mon_e.ps || bus0.PLP_OUT !== mon_e.plp) begin
                        fails++;
                        $display("FAIL strobe: got dv=%b data=%h ps=%b plp=%0d expected dv=%b data=%h ps=%b plp=%0d",
                                 bus0.D_VALID_OUT, bus0.DATA_OUT, bus0.P_SYNC_OUT, bus0.PLP_OUT,
                                 mon_e.ch, mon_e.data, mon_e.ps, mon_e.plp);
                    end
                end
            end else if (bus0.P_SYNC_OUT != 4'b0000) begin
                tests++;
                fails++;
                $display("FAIL stray_psync: got %b expected 0000", bus0.P_SYNC_OUT);
            end
            if (bus0.ERR_PULSE != 3'b000) begin
                tests++;
                if (err_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_err: got %b expected none", bus0.ERR_PULSE);
                end else begin
                    mon_err = err_q.pop_front();
                    if (bus0.ERR_PULSE !== mon_err) begin
                        fails++;
                        $display("FAIL err_pulse: got %b expected %b", bus0.ERR_PULSE, mon_err);
                    end
                end
            end
            if (bus1.D_VALID_OUT == 4'b0010) cnt1_ch1++;
        end
    end

    task automatic drive(input logic [7:0] d, input logic v, input logic ps);
        bus0.DATA_IN = d; bus0.D_VALID_IN = v; bus0.P_SYNC_IN = ps;
        bus1.DATA_IN = d; bus1.D_VALID_IN = v; bus1.P_SYNC_IN = ps;
        @(posedge clk);
        #1;
    endtask

    // One packet: header, nts TS bytes (byte0 = ts0, byte i = i), one gap cycle.
    task automatic send_packet(input logic [7:0] plp, input logic [7:0] src,
                               input logic [7:0] ts0, input logic ps, input int nts,
                               input int exp_ch, input int exp_n, input logic [2:0] exp_err);
        strobe_t e;
        for (int i = 0; i < exp_n; i++) begin
            e.ch   = 4'b0001 << exp_ch;
            e.data = (i == 0) ? ts0 : 8'(i);
            e.ps   = (i == 0) ? e.ch : 4'b0000;
            e.plp  = 2'(exp_ch);
            exp_q.push_back(e);
        end
        if (exp_err != 3'b000) err_q.push_back(exp_err);
        drive(plp, 1'b1, 1'b0);
        drive(src, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < nts; i++)
            drive((i == 0) ? ts0 : 8'(i), 1'b1, (i == 0) ? ps : 1'b0);
        drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_strobes_left"}, exp_q.size(), 0);
        check({name, "_errs_left"}, err_q.size(), 0);
    endtask

    int base[4];
    int c1;

    initial begin
        bus0.DATA_IN = '0; bus0.D_VALID_IN = 1'b0; bus0.P_SYNC_IN = 1'b0;
        bus1.DATA_IN = '0; bus1.D_VALID_IN = 1'b0; bus1.P_SYNC_IN = 1'b0;
        #1 rst_n = 1'b0;
        #3;
        check("rst_dv", bus0.D_VALID_OUT, 0);
        check("rst_ps", bus0.P_SYNC_OUT, 0);
        check("rst_data", bus0.DATA_OUT, 0);
        check("rst_plp", bus0.PLP_OUT, 0);
        check("rst_err", bus0.ERR_PULSE, 0);
        check("rst_cnt", bus0.ERR_COUNT, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Good packet on ch2.
        send_packet(8'd2, 8'd4, 8'h47, 1'b1, 188, 2, 188, 3'b000);
        drain("good");
        check("good_cnt_ch2", strobe_cnt[2], 188);
        check("good_errcnt", bus0.ERR_COUNT, 0);

        // Round robin with 1-cycle gaps.
        for (int k = 0; k < 4; k++) base[k] = strobe_cnt[k];
        for (int k = 0; k < 4; k++)
            send_packet(8'(k), 8'(k + 2), 8'h47, 1'b1, 188, k, 188, 3'b000);
        drain("rr");
        for (int k = 0; k < 4; k++)
            check($sformatf("rr_cnt_ch%0d", k), strobe_cnt[k] - base[k], 188);
        check("rr_plp_last", bus0.PLP_OUT, 3);

        // Bad header: PLP out of range, then bad source (forwarded when unchecked).
        send_packet(8'd5, 8'd7, 8'h47, 1'b1, 188, 0, 0, 3'b001);
        c1 = cnt1_ch1;
        send_packet(8'd1, 8'd7, 8'h47, 1'b1, 188, 0, 0, 3'b001);
        drain("badhdr");
        check("badhdr_errcnt", bus0.ERR_COUNT, 2);
        check("nocheck_ch1_cnt", cnt1_ch1 - c1, 188);

        // Sync errors, then a good packet.
        send_packet(8'd0, 8'd2, 8'h46, 1'b1, 188, 0, 0, 3'b010);
        send_packet(8'd0, 8'd2, 8'h47, 1'b0, 188, 0, 0, 3'b010);
        send_packet(8'd3, 8'd5, 8'h47, 1'b1, 188, 3, 188, 3'b000);
        drain("sync");
        check("sync_errcnt", bus0.ERR_COUNT, 4);

        // Truncated, overlength, then recovery.
        base[1] = strobe_cnt[1];
        send_packet(8'd1, 8'd3, 8'h47, 1'b1, 100, 1, 100, 3'b100);
        drain("trunc");
        check("trunc_cnt", strobe_cnt[1] - base[1], 100);
        send_packet(8'd2, 8'd4, 8'h47, 1'b1, 196, 2, 188, 3'b100);
        send_packet(8'd0, 8'd2, 8'h47, 1'b1, 188, 0, 188, 3'b000);
        drain("overlen");
        check("len_errcnt", bus0.ERR_COUNT, 6);

        // Reset while TS byte 50 is on the input; byte 49's strobe is squashed.
        base[1] = strobe_cnt[1];
        for (int i = 0; i < 49; i++) begin
            strobe_t e;
            e.ch = 4'b0010; e.plp = 2'd1;
            e.data = (i == 0) ? 8'h47 : 8'(i);
            e.ps = (i == 0) ? 4'b0010 : 4'b0000;
            exp_q.push_back(e);
        end
        drive(8'd1, 1'b1, 1'b0);
        drive(8'd3, 1'b1, 1'b0);
        drive(8'd0, 1'b1, 1'b0);
        drive(8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++)
            drive((i == 0) ? 8'h47 : 8'(i), 1'b1, (i == 0) ? 1'b1 : 1'b0);
        bus0.DATA_IN = 8'd50; bus1.DATA_IN = 8'd50;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dv", bus0.D_VALID_OUT, 0);
        check("midrst_ps", bus0.P_SYNC_OUT, 0);
        check("midrst_data", bus0.DATA_OUT, 0);
        check("midrst_errcnt", bus0.ERR_COUNT, 0);
        check("midrst_cnt", strobe_cnt[1] - base[1], 49);
        bus0.D_VALID_IN = 1'b0; bus1.D_VALID_IN = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_packet(8'd1, 8'd3, 8'h47, 1'b1, 188, 1, 188, 3'b000);
        drain("postrst");
        check("postrst_cnt", strobe_cnt[1] - base[1], 49 + 188);
        check("postrst_errcnt", bus0.ERR_COUNT, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
